// File: rtl/imem_port_arbiter.sv
// Instruction memory port sequencer: zero-clear, boot-time loader writes, then fetch-priority sharing with late loader writes.
// Fetch reads return one cycle after grant; IMEM_STARVE_GUARD_EN lets a blocked loader win one slot after STARVE_LIMIT cycles.
module imem_port_arbiter #(
  parameter int DEPTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_BOOT  = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_hold_q, rdata_hold_d;
  logic          starve_win;
  logic          fetch_addr_ok;

  assign fetch_addr_ok = (fetch_addr[1:0] == 2'b00) && ((fetch_addr >> 2) < DEPTH_W);

`ifdef IMEM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_win = (state_q == ST_RUN) && (starve_cnt_q == STARVE_MAX);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (reset || (state_q != ST_RUN) || starve_win || (ld_valid && ld_ready))
      starve_cnt_d = '0;
    else if (ld_valid && fetch_req)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    starve_cnt_q <= starve_cnt_d;
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;

  assign starve_win = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    cpu_stall = 1'b1;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1))
          state_d = ST_BOOT;
      end
      ST_BOOT: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end
        if (ld_done)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        if (starve_win) begin
          ld_ready = 1'b1;
        end else begin
          fetch_gnt = fetch_req;
          ld_ready  = ~fetch_req;
        end
        if (fetch_gnt) begin
          // Bad addresses still complete, with err, so the fetch stage never waits forever.
          rvalid_d = 1'b1;
          err_d    = ~fetch_addr_ok;
          if (fetch_addr_ok) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[AW+1:2];
          end
        end else if (ld_valid && ld_ready) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (reset) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      fetch_gnt = 1'b0;
      ld_ready  = 1'b0;
      cpu_stall = 1'b1;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Read data comes straight from the array's output register; hold it between responses.
  always_comb begin
    if (reset)
      fetch_rdata = '0;
    else if (rvalid_q)
      fetch_rdata = err_q ? 32'h0 : mem_rdata;
    else
      fetch_rdata = rdata_hold_q;
  end

  assign rdata_hold_d = fetch_rdata;
  assign fetch_rvalid = rvalid_q & ~reset;
  assign fetch_err    = err_q & ~reset;
  assign state_o      = reset ? ST_CLEAR : state_q;

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    clr_cnt_q    <= clr_cnt_d;
    rvalid_q     <= rvalid_d;
    err_q        <= err_d;
    rdata_hold_q <= rdata_hold_d;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter with a behavioural memory model and a response scoreboard.
module tb_imem_port_arbiter;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;
`ifdef IMEM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_rdata;
  logic          ld_valid, ld_ready, ld_done;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          cpu_stall, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [1:0]    state_o;

  imem_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Synchronous single-port array, seeded with garbage so the clear phase matters.
  logic [31:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected memory contents, phase, and blocked-loader streak.
  logic [31:0]   ref_mem [DEPTH];
  int            m_phase   = 0;
  int            m_clr     = 0;
  int            m_blocked = 0;
  logic [32:0]   exp_q [$];

  // Monitor: pops expected {err, rdata} whenever a response is presented.
  logic [31:0] last_rdata = '0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      last_rdata = '0;
    end else if (fetch_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", 64'(fetch_rvalid), 64'(0));
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_err", 64'(fetch_err), 64'(e[32]));
        chk("rsp_rdata", 64'(fetch_rdata), 64'(e[31:0]));
        last_rdata = e[31:0];
      end
    end else begin
      chk("rdata_hold", 64'(fetch_rdata), 64'(last_rdata));
    end
  end

  task automatic cyc(input logic rst, input logic freq, input logic [31:0] fa,
                     input logic lv, input logic [AW-1:0] la, input logic [31:0] ld,
                     input logic ldone);
    logic [4:0]  exp_ctrl;
    logic [38:0] exp_mem;
    logic        turn, eg, elr, ok;
    reset = rst; fetch_req = freq; fetch_addr = fa;
    ld_valid = lv; ld_addr = la; ld_data = ld; ld_done = ldone;
    if (rst) exp_q.delete();
    @(negedge clk);
    exp_mem = '0;
    if (rst) begin
      exp_ctrl = {2'b00, 1'b1, 1'b0, 1'b0};
      chk("rst_rsp", {31'b0, fetch_rvalid, fetch_err, fetch_rdata}, 64'(0));
      m_phase = 0; m_clr = 0; m_blocked = 0;
    end else if (m_phase == 0) begin
      exp_ctrl = {2'b00, 1'b1, 1'b0, 1'b0};
      exp_mem  = {1'b1, 1'b1, AW'(m_clr), 32'h0};
      ref_mem[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_phase = 1;
    end else if (m_phase == 1) begin
      exp_ctrl = {2'b01, 1'b1, 1'b1, 1'b0};
      if (lv) begin
        exp_mem = {1'b1, 1'b1, la, ld};
        ref_mem[la] = ld;
      end
      if (ldone) m_phase = 2;
    end else begin
      turn = GUARD && (m_blocked == LIMIT);
      eg   = freq && !turn;
      elr  = turn || !freq;
      exp_ctrl = {2'b10, 1'b0, elr, eg};
      if (eg) begin
        ok = (fa[1:0] == 2'b00) && (fa < 32'(DEPTH * 4));
        exp_q.push_back({!ok, ok ? ref_mem[fa[AW+1:2]] : 32'h0});
        if (ok) exp_mem = {1'b1, 1'b0, fa[AW+1:2], 32'h0};
      end else if (lv && elr) begin
        exp_mem = {1'b1, 1'b1, la, ld};
        ref_mem[la] = ld;
      end
      if ((lv && elr) || turn) m_blocked = 0;
      else if (lv && freq)     m_blocked++;
    end
    chk("ctrl", 64'({state_o, cpu_stall, ld_ready, fetch_gnt}), 64'(exp_ctrl));
    chk("mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'(exp_mem));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0)      return {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
    else if (r == 1) return 32'(DEPTH * 4) + 32'($urandom_range(0, 1023) * 4);
    else             return 32'({$urandom_range(0, DEPTH - 1), 2'b00});
  endfunction

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h8C080000; prog[1] = 32'h8C090020;
    prog[2] = 32'h8C0A0050; prog[3] = 32'h8C0B0008;
    reset = 1'b1; fetch_req = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 1, 3, 32'hDEAD, 0);
    // Clear phase with noise on the requesters.
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 1'($urandom), $urandom, 1'($urandom), AW'($urandom), $urandom, 0);
    // Boot loading.
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, AW'(i), prog[i], 0);
    for (int i = 4; i < 16; i++) begin
      cyc(0, 1'($urandom), 0, 1, AW'(i), $urandom, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 20, 32'hCAFEF00D, 1);
    // Run: directed fetches, good and bad.
    cyc(0, 1, 32'h4, 0, 0, 0, 0);
    cyc(0, 1, 32'h8, 0, 0, 0, 0);
    cyc(0, 1, 32'h6, 0, 0, 0, 0);
    cyc(0, 1, 32'h80, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h50, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc(0, ($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom), AW'($urandom),
          $urandom, 1'($urandom_range(0, 15) == 0));
    // Sustained contention.
    cyc(0, 0, 0, 1, 7, 32'h11111111, 0);
    for (int i = 0; i < 12; i++)
      cyc(0, 1, 32'({$urandom_range(0, DEPTH - 1), 2'b00}), 1, 9, 32'h22220000 + 32'(i), 0);
    cyc(0, 1, 32'h24, 0, 0, 0, 0);
    // Reset right after a grant cancels the response and restarts clearing.
    cyc(0, 1, 32'h0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, 32'h4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
